// File: rtl/imem_fetch_queue.sv
// imem_fetch_queue: credit-based fetch queue between the warp scheduler, the
// instruction memory (no response backpressure) and decode. A request is only
// issued when a slot is reserved for its response; responses are paired with
// their PC in order and handed to decode over valid/ready. Flush discards
// buffered entries and marks all in-flight responses for drop.
module imem_fetch_queue #(
  parameter int unsigned ARCH_LEN      = 32,
  parameter int unsigned INST_BITS     = 64,
  parameter int unsigned IMEM_TAG_BITS = 64,
  parameter int unsigned DEPTH         = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [IMEM_TAG_BITS-1:0] in_bits_tag,
  input  logic [ARCH_LEN-1:0]      in_bits_pc,
  output logic                     imem_req_valid,
  output logic [IMEM_TAG_BITS-1:0] imem_req_bits_tag,
  output logic [ARCH_LEN-1:0]      imem_req_bits_pc,
  input  logic                     imem_resp_valid,
  input  logic [IMEM_TAG_BITS-1:0] imem_resp_bits_tag,
  input  logic [INST_BITS-1:0]     imem_resp_bits_inst,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IMEM_TAG_BITS-1:0] out_bits_tag,
  output logic [ARCH_LEN-1:0]      out_bits_pc,
  output logic [INST_BITS-1:0]     out_bits_inst,
  output logic                     err_tag
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned SUM_W = CNT_W + 1;

  // Pending FIFO: {tag, pc} of issued requests awaiting their response
  logic [IMEM_TAG_BITS-1:0] pend_tag [DEPTH];
  logic [ARCH_LEN-1:0]      pend_pc  [DEPTH];
  logic [PTR_W-1:0]         pend_wr;
  logic [PTR_W-1:0]         pend_rd;
  logic [CNT_W-1:0]         inflight;

  // Data FIFO: completed {tag, pc, inst} entries waiting for decode
  logic [IMEM_TAG_BITS-1:0] data_tag  [DEPTH];
  logic [ARCH_LEN-1:0]      data_pc   [DEPTH];
  logic [INST_BITS-1:0]     data_inst [DEPTH];
  logic [PTR_W-1:0]         data_wr;
  logic [PTR_W-1:0]         data_rd;
  logic [CNT_W-1:0]         buffered;

  logic [CNT_W-1:0]         drop;

  logic [SUM_W-1:0]         credit_sum;
  logic                     req_fire;
  logic                     pend_empty;
  logic                     resp_pop;
  logic                     resp_keep;
  logic                     resp_err;
  logic                     out_fire;
  logic [CNT_W-1:0]         inflight_nxt;
  logic [CNT_W-1:0]         buffered_nxt;

  // Credit check uses registered counts only, so in_ready never depends on
  // this cycle's response or decode handshake.
  assign credit_sum = SUM_W'(inflight) + SUM_W'(buffered);
  assign in_ready   = ~flush & (credit_sum < SUM_W'(DEPTH));
  assign req_fire   = in_valid & in_ready;

  assign imem_req_valid    = req_fire;
  assign imem_req_bits_tag = in_bits_tag;
  assign imem_req_bits_pc  = in_bits_pc;

  // A response with nothing pending is flagged and otherwise ignored.
  assign pend_empty = (inflight == '0);
  assign resp_pop   = imem_resp_valid & ~pend_empty;
  assign resp_keep  = resp_pop & ~flush & (drop == '0);
  assign resp_err   = imem_resp_valid &
                      (pend_empty | (imem_resp_bits_tag != pend_tag[pend_rd]));

  assign out_valid     = (buffered != '0);
  assign out_fire      = out_valid & out_ready & ~flush;
  assign out_bits_tag  = data_tag[data_rd];
  assign out_bits_pc   = data_pc[data_rd];
  assign out_bits_inst = data_inst[data_rd];

  // Next occupancy counts; simultaneous push/pop cancel out
  always_comb begin
    inflight_nxt = inflight + CNT_W'(req_fire) - CNT_W'(resp_pop);
    buffered_nxt = buffered + CNT_W'(resp_keep) - CNT_W'(out_fire);
    if (flush) begin
      buffered_nxt = '0;
    end
  end

  // Pointers, counts, drop counter and sticky error flag
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pend_wr  <= '0;
      pend_rd  <= '0;
      inflight <= '0;
      data_wr  <= '0;
      data_rd  <= '0;
      buffered <= '0;
      drop     <= '0;
      err_tag  <= 1'b0;
    end else begin
      inflight <= inflight_nxt;
      buffered <= buffered_nxt;
      if (req_fire) begin
        pend_wr <= pend_wr + PTR_W'(1);
      end
      if (resp_pop) begin
        pend_rd <= pend_rd + PTR_W'(1);
      end
      if (flush) begin
        data_wr <= '0;
        data_rd <= '0;
      end else begin
        if (resp_keep) begin
          data_wr <= data_wr + PTR_W'(1);
        end
        if (out_fire) begin
          data_rd <= data_rd + PTR_W'(1);
        end
      end
      // Everything still in flight after a flush belongs to the old stream
      if (flush) begin
        drop <= inflight_nxt;
      end else if (resp_pop && (drop != '0)) begin
        drop <= drop - CNT_W'(1);
      end
      if (resp_err) begin
        err_tag <= 1'b1;
      end
    end
  end

  // FIFO storage writes; contents need no reset
  always_ff @(posedge clock) begin
    if (req_fire) begin
      pend_tag[pend_wr] <= in_bits_tag;
      pend_pc[pend_wr]  <= in_bits_pc;
    end
    if (resp_keep) begin
      data_tag[data_wr]  <= pend_tag[pend_rd];
      data_pc[data_wr]   <= pend_pc[pend_rd];
      data_inst[data_wr] <= imem_resp_bits_inst;
    end
  end

endmodule
